// File: rtl/fft_mag_pkg.sv
// Shared types and default sizing for the FFT magnitude-squared stream.
package fft_mag_pkg;

  localparam int DEF_NSAMPLES = 1024;
  localparam int DEF_WIN      = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

endpackage

// File: rtl/fft_mag_square.sv
// Registered signed square of one FFT component; the register loads only on enable.
module fft_mag_square
  import fft_mag_pkg::*;
#(
  parameter int WIn = DEF_WIN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_en,
  input  logic [WIn-1:0]     i_x,
  output logic [2*WIn-1:0]   o_sq
);

  logic signed [2*WIn-1:0] w_prod;
  logic [2*WIn-1:0]        r_sq;

  // Operands sign-extend to 2*WIn before multiplying, so the square is exact.
  assign w_prod = $signed(i_x) * $signed(i_x);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sq <= '0;
    end else if (i_en) begin
      r_sq <= $unsigned(w_prod);
    end
  end

  assign o_sq = r_sq;

endmodule

// File: rtl/fft_mag_stream.sv
// Two-stage re^2+im^2 pipeline with window framing checks.
// Define FFT_MAG_KIDX_EN to add the natural-order bin index output mag_k.
module fft_mag_stream
  import fft_mag_pkg::*;
#(
  parameter int NSamples = DEF_NSAMPLES,
  parameter int WIn      = DEF_WIN,
  parameter int W        = 2*WIn+1,
  parameter int NBits    = $clog2(NSamples)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIn-1:0]   re,
  input  logic [WIn-1:0]   im,
  input  logic             in_valid,
  input  logic             in_last,
  output logic [W-1:0]     mag,
  output logic             mag_valid,
  output logic             mag_last,
  output logic             frame_err
`ifdef FFT_MAG_KIDX_EN
  ,
  output logic [NBits-1:0] mag_k
`endif
);

  localparam logic [NBits-1:0] LastIdx = NBits'(NSamples - 1);

  state_t           r_state, w_state_next;
  logic [NBits-1:0] r_cnt, w_cnt_next;
  logic             w_at_end, w_close, w_err;
  logic [2*WIn-1:0] w_re_sq, w_im_sq;

  logic             r_s1_valid, r_s1_last, r_s1_err;
  logic [W-1:0]     r_mag;
  logic             r_mag_valid, r_mag_last, r_frame_err;

  fft_mag_square #(.WIn(WIn)) u_sq_re (
    .clk(clk), .reset(reset), .i_en(in_valid), .i_x(re), .o_sq(w_re_sq)
  );

  fft_mag_square #(.WIn(WIn)) u_sq_im (
    .clk(clk), .reset(reset), .i_en(in_valid), .i_x(im), .o_sq(w_im_sq)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // A window closes on in_last or on the final index; a mismatch between the two is a framing error.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_at_end     = (r_cnt == LastIdx);
    w_close      = 1'b0;
    w_err        = 1'b0;
    if (in_valid) begin
      w_close = in_last | w_at_end;
      w_err   = in_last ^ w_at_end;
      if (w_close) begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end else begin
        w_state_next = FRAME;
        w_cnt_next   = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_err    <= 1'b0;
      r_mag       <= '0;
      r_mag_valid <= 1'b0;
      r_mag_last  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_s1_valid  <= in_valid;
      r_s1_last   <= w_close;
      r_s1_err    <= w_err;
      r_mag_valid <= r_s1_valid;
      r_mag_last  <= r_s1_last;
      r_frame_err <= r_s1_err;
      // mag holds its previous value through gaps.
      if (r_s1_valid) begin
        r_mag <= W'(w_re_sq) + W'(w_im_sq);
      end
    end
  end

  assign mag       = r_mag;
  assign mag_valid = r_mag_valid;
  assign mag_last  = r_mag_last;
  assign frame_err = r_frame_err;

`ifdef FFT_MAG_KIDX_EN
  logic [NBits-1:0] w_cnt_rev;
  logic [NBits-1:0] r_s1_k, r_mag_k;

  // FFT output arrives bit-reversed; reversing the count gives the natural bin.
  for (genvar gi = 0; gi < NBits; gi++) begin : g_rev
    assign w_cnt_rev[gi] = r_cnt[NBits-1-gi];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_k  <= '0;
      r_mag_k <= '0;
    end else begin
      if (in_valid) begin
        r_s1_k <= w_cnt_rev;
      end
      if (r_s1_valid) begin
        r_mag_k <= r_s1_k;
      end
    end
  end

  assign mag_k = r_mag_k;
`endif

endmodule

// File: tb/tb_fft_mag_stream.sv
// Randomized bench for fft_mag_stream against a queue-based model of expected outputs.
module tb_fft_mag_stream;

  localparam int N  = 1024;
  localparam int NB = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] re, im;
  logic        in_valid, in_last;
  logic [32:0] mag;
  logic        mag_valid, mag_last, frame_err;
`ifdef FFT_MAG_KIDX_EN
  logic [NB-1:0] mag_k;
`endif

  fft_mag_stream dut (
    .clk(clk), .reset(reset), .re(re), .im(im),
    .in_valid(in_valid), .in_last(in_last),
    .mag(mag), .mag_valid(mag_valid), .mag_last(mag_last), .frame_err(frame_err)
`ifdef FFT_MAG_KIDX_EN
    , .mag_k(mag_k)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int     due;
    longint m;
    bit     l;
    bit     e;
    int     k;
  } exp_t;

  exp_t   q[$];
  int     cyc = 0;
  int     idx = 0;
  longint last_mag = 0;
  bit     mon_en = 0;
  int     total = 0;
  int     bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < NB; b++) if (v[b]) r |= 1 << (NB - 1 - b);
    return r;
  endfunction

  // Each valid sample becomes one expected output two cycles later.
  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b, input bit l);
    exp_t e;
    bit   at_end = (idx == N - 1);
    re = a; im = b; in_valid = 1'b1; in_last = l;
    e.due = cyc + 2;
    e.m   = longint'(a) * longint'(a) + longint'(b) * longint'(b);
    e.l   = l || at_end;
    e.e   = l != at_end;
    e.k   = bitrev(idx);
    q.push_back(e);
    idx = e.l ? 0 : idx + 1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'($urandom); re = 16'($urandom); im = 16'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0; in_last = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    int r_c = cyc;
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    while (q.size() > 0 && q[q.size()-1].due > r_c) void'(q.pop_back());
    idx = 0;
    last_mag = 0;
  endtask

  task automatic window(input int n, input bit with_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send(16'($urandom), 16'($urandom), with_last && (i == n - 1));
      if (gaps && ($urandom % 4 == 0)) idle($urandom_range(1, 3));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("valid", 64'(mag_valid), 64'd1);
        check("mag", 64'(mag), 64'(e.m));
        check("last", 64'(mag_last), 64'(e.l));
        check("err", 64'(frame_err), 64'(e.e));
`ifdef FFT_MAG_KIDX_EN
        check("kidx", 64'(mag_k), 64'(e.k));
`endif
        last_mag = e.m;
        $display("out cyc=%0d mag=%0d last=%0b err=%0b", cyc, mag, mag_last, frame_err);
      end else begin
        check("idle_valid", 64'(mag_valid), 64'd0);
        check("hold_mag", 64'(mag), 64'(last_mag));
        check("idle_last", 64'(mag_last), 64'd0);
        check("idle_err", 64'(frame_err), 64'd0);
      end
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; re = '0; im = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mag", 64'(mag), 64'd0);
    check("rst_valid", 64'(mag_valid), 64'd0);
    check("rst_last", 64'(mag_last), 64'd0);
    check("rst_err", 64'(frame_err), 64'd0);
`ifdef FFT_MAG_KIDX_EN
    check("rst_kidx", 64'(mag_k), 64'd0);
`endif
    mon_en = 1'b1;
    reset = 1'b1;
    idle(2);

    send(16'sd3, -16'sd4, 1'b0);
    idle(3);
    send(-16'sd32768, -16'sd32768, 1'b0);
    idle(3);
    do_reset();
    idle(2);

    window(N, 1'b1, 1'b1);
    idle(2);
    window(10, 1'b1, 1'b0);
    window(N, 1'b1, 1'b0);
    window(N, 1'b0, 1'b1);
    idle(2);
    window(501, 1'b0, 1'b0);
    do_reset();
    idle(1);
    window(N, 1'b1, 1'b1);
    idle(5);

    check("drain", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_mag_stream.md
FFT_MAG_STREAM -- requirements
Module: fft_mag_stream

Interface
REQ-001 SHALL have parameter NSamples, default 1024, FFT window length in samples (power of two, >= 4).
REQ-002 SHALL have parameter WIn, default 16, signed width of each real/imag input.
REQ-003 SHALL have parameter W, default 2*WIn+1 (33), magnitude-squared output width.
REQ-004 SHALL have parameter NBits, default $clog2(NSamples), bin-index width.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port re  input  WIn  signed real part of FFT output sample.
REQ-008 SHALL have port im  input  WIn  signed imaginary part of FFT output sample.
REQ-009 SHALL have port in_valid  input  1  re/im valid this cycle.
REQ-010 SHALL have port in_last  input  1  marks last sample of window (qualified by in_valid).
REQ-011 SHALL have port mag  output  W  re^2+im^2, unsigned.
REQ-012 SHALL have port mag_valid  output  1  mag valid this cycle.
REQ-013 SHALL have port mag_last  output  1  mag is last sample of window.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on window framing error.

Function
REQ-015 SHALL compute mag = re*re + im*im exactly, signed products, zero-extended sum to W bits; (-2^(WIn-1))^2 + (-2^(WIn-1))^2 = 2^(2*WIn-1) SHALL not overflow.
REQ-016 SHALL have fixed latency 2 cycles: stage 1 registers both squares, stage 2 registers sum; mag_valid = in_valid delayed 2 cycles.
REQ-017 SHALL accept gaps: in_valid low cycles produce mag_valid low, no bubble compression, no stall input.
REQ-018 SHALL hold mag at last valid value while mag_valid low.
REQ-019 SHALL keep sample counter cnt (NBits), advancing on each in_valid; FSM states IDLE (cnt==0, no frame open) and FRAME.
REQ-020 SHALL transition IDLE->FRAME on first in_valid without in_last; FRAME->IDLE on in_valid with cnt==NSamples-1.
REQ-021 SHALL assert mag_last (aligned with mag_valid) for sample where cnt==NSamples-1 and in_last=1; cnt -> 0.
REQ-022 SHALL, on in_last with cnt!=NSamples-1 (short window), pulse frame_err 2 cycles later aligned with that sample, assert mag_last, and return cnt to 0.
REQ-023 SHALL, on cnt==NSamples-1 without in_last (long window), pulse frame_err aligned with that sample, assert mag_last, and wrap cnt to 0.
REQ-024 SHALL ignore in_last when in_valid=0.

Reset
REQ-025 SHALL, with reset=0 at rising clk, clear both pipeline stages, mag=0, mag_valid=0, mag_last=0, frame_err=0, cnt=0, FSM=IDLE.
REQ-026 SHALL discard in-flight samples when reset asserted mid-window; first post-reset valid sample is index 0.

Configuration
REQ-027 SHALL support macro FFT_MAG_KIDX_EN: when defined, add output port mag_k  output  NBits, bin index of mag in natural order = bit-reverse of cnt (FFT output arrives bit-reversed), aligned with mag_valid, reset 0.
REQ-028 SHALL, without FFT_MAG_KIDX_EN, omit mag_k port and its pipeline registers; all other behaviour identical.

Structure
REQ-029 SHALL place FSM state typedef (IDLE, FRAME) and default constants (NSamples, WIn) in package fft_mag_pkg.
REQ-030 SHALL implement stage 1 in sub-module fft_mag_square (registered signed square, one per component, two instances).

Verification
REQ-031 SHALL test re=3, im=-4 single valid -> mag=25, mag_valid exactly 2 cycles later, one cycle wide.
REQ-032 SHALL test re=im=-32768 -> mag=2147483648 (bit 31 set, bit 32 clear).
REQ-033 SHALL test full 1024-sample window, in_last on sample 1023, random gaps -> 1024 mag_valid, mag_last only on 1024th, frame_err never.
REQ-034 SHALL test in_last on sample 9 -> frame_err and mag_last pulse with 10th mag_valid, next sample restarts at index 0.
REQ-035 SHALL test reset low for 1 cycle after sample 500 -> no mag_valid from in-flight samples, next window counted from 0.
REQ-036 SHALL test with FFT_MAG_KIDX_EN, NSamples=1024: sample 1 -> mag_k=512, sample 2 -> mag_k=256, sample 1023 -> mag_k=1023.
